// File: rtl/mips_instr_encoder_pkg.sv
// mips_instr_encoder_pkg
//   Shared definitions for the MIPS32 instruction encoder: request kind
//   codes, the opcode/funct values the encoder emits or checks, and the
//   encoder FSM state type.
//   Optional feature macro: ENC_PSEUDO_EN (LI/MOVE/NOP pseudo-instructions).
package mips_instr_encoder_pkg;

    // Request kinds; 3'd7 is deliberately left undefined (illegal).
    typedef enum logic [2:0] {
        KIND_R     = 3'd0,
        KIND_SHIFT = 3'd1,
        KIND_I     = 3'd2,
        KIND_J     = 3'd3,
        KIND_LI    = 3'd4,
        KIND_MOVE  = 3'd5,
        KIND_NOP   = 3'd6
    } kind_t;

    // Opcodes
    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;

    // R-type funct
    localparam logic [5:0] FN_ADDU   = 6'b100001;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC0_0000;

    // IDLE accepts requests; LI2 holds the ORI half of a two-word LI.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LI2  = 1'b1
    } state_t;

    // I-format helper shared by the LI expansion paths.
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// mips_instr_encoder_if
//   Request and output stream bundle of the instruction encoder.
//   Request side : req_valid/req_ready handshake with kind, code and fields.
//   Output side  : out_valid/out_ready handshake with out_instr/out_addr.
//   master modport: the requester / loader (drives requests, out_ready).
//   slave  modport: the encoder.
interface mips_instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [5:0]  req_code;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [4:0]  req_sa;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;

    modport master (
        output req_valid, req_kind, req_code, req_rs, req_rt, req_rd, req_sa, req_imm,
        output out_ready,
        input  req_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  req_valid, req_kind, req_code, req_rs, req_rt, req_rd, req_sa, req_imm,
        input  out_ready,
        output req_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/mips_instr_encoder_instr_pack.sv
// instr_pack
//   Combinational packer: turns a request kind, code and register/immediate
//   fields into one 32-bit MIPS32 word and flags whether the request is legal.
//   For LI it returns the first word (ORI or LUI) and raises two_word when an
//   ORI follow-up is needed.
//   Ports: kind, code, rs, rt, rd, sa, imm (in); word, legal, two_word (out).
//   Optional feature macro: ENC_PSEUDO_EN enables KIND_LI/KIND_MOVE/KIND_NOP.
import mips_instr_encoder_pkg::*;

module instr_pack (
    input  logic [2:0]  kind,
    input  logic [5:0]  code,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal,
    output logic        two_word
);

    always_comb begin
        word     = '0;
        legal    = 1'b0;
        two_word = 1'b0;
        case (kind)
            KIND_R: begin
                word  = {OP_R_TYPE, rs, rt, rd, 5'd0, code};
                legal = 1'b1;
            end
            KIND_SHIFT: begin
                word  = {OP_R_TYPE, 5'd0, rt, rd, sa, code};
                legal = 1'b1;
            end
            KIND_I: begin
                word  = {code, rs, rt, imm[15:0]};
                // R-type and jump opcodes cannot be expressed in I format
                legal = !(code == OP_R_TYPE || code == OP_J || code == OP_JAL);
            end
            KIND_J: begin
                word  = {code, imm[25:0]};
                legal = (code == OP_J || code == OP_JAL);
            end
`ifdef ENC_PSEUDO_EN
            KIND_LI: begin
                legal = 1'b1;
                if (imm[31:16] == 16'h0) begin
                    word = enc_i(OP_ORI, 5'd0, rt, imm[15:0]);
                end else begin
                    word     = enc_i(OP_LUI, 5'd0, rt, imm[31:16]);
                    two_word = (imm[15:0] != 16'h0);
                end
            end
            KIND_MOVE: begin
                word  = {OP_R_TYPE, rs, 5'd0, rd, 5'd0, FN_ADDU};
                legal = 1'b1;
            end
            KIND_NOP: begin
                word  = '0;
                legal = 1'b1;
            end
`endif
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

`ifndef ENC_PSEUDO_EN
    // Upper immediate bits only matter for LI.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:26];
`endif

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Assembles MIPS32 instruction words from field-level requests and streams
//   them with sequential load addresses to the instruction-RAM loader.
//   LI and MOVE pseudo-instructions are expanded; LI may take two beats.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     restart       synchronous soft restart (same effect as rst, top priority)
//     bus           mips_instr_encoder_if.slave: request and output streams
//     err           sticky: an illegal request was consumed and dropped
//   Parameter: BASE_ADDR, load address of the first word after reset/restart.
//   Optional feature macro: ENC_PSEUDO_EN (LI/MOVE/NOP and the LI2 state).
import mips_instr_encoder_pkg::*;

module mips_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       restart,
    mips_instr_encoder_if.slave        bus,
    output logic                       err
);

    logic        soft_rst;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_addr_q;
    logic        err_q;

    logic        idle;
    logic        out_free;
    logic        accept;
    logic        load_word;

    logic [2:0]  p_kind;
    logic [5:0]  p_code;
    logic [4:0]  p_rs;
    logic [4:0]  p_rt;
    logic [4:0]  p_rd;
    logic [4:0]  p_sa;
    logic [31:0] p_imm;
    logic [31:0] p_word;
    logic        p_legal;
    logic        p_two;

    assign soft_rst = rst | restart;

    // Output stage can take a word when empty or draining this cycle.
    assign out_free      = !out_valid_q | bus.out_ready;
    assign bus.req_ready = idle & out_free;
    assign accept        = bus.req_valid & bus.req_ready;

`ifdef ENC_PSEUDO_EN
    state_t      state_q;
    state_t      state_d;
    logic [4:0]  li_rt_q;
    logic [15:0] li_lo_q;
    logic        li2_load;

    assign idle     = (state_q == ST_IDLE);
    assign li2_load = (state_q == ST_LI2) & out_free;

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && p_legal && p_two) state_d = ST_LI2;
            ST_LI2:  if (out_free) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The pending ORI half reuses the packer: in LI2 the request fields are
    // ignored (req_ready is low) and an ORI rt, rt, lo request is fed in.
    always_comb begin
        p_kind = bus.req_kind;
        p_code = bus.req_code;
        p_rs   = bus.req_rs;
        p_rt   = bus.req_rt;
        p_rd   = bus.req_rd;
        p_sa   = bus.req_sa;
        p_imm  = bus.req_imm;
        if (state_q == ST_LI2) begin
            p_kind = KIND_I;
            p_code = OP_ORI;
            p_rs   = li_rt_q;
            p_rt   = li_rt_q;
            p_imm  = {16'h0, li_lo_q};
        end
    end

    always_ff @(posedge clk) begin
        if (accept && p_legal && p_two) begin
            li_rt_q <= bus.req_rt;
            li_lo_q <= bus.req_imm[15:0];
        end
    end

    assign load_word = li2_load | (accept & p_legal);
`else
    assign idle      = 1'b1;
    assign p_kind    = bus.req_kind;
    assign p_code    = bus.req_code;
    assign p_rs      = bus.req_rs;
    assign p_rt      = bus.req_rt;
    assign p_rd      = bus.req_rd;
    assign p_sa      = bus.req_sa;
    assign p_imm     = bus.req_imm;
    assign load_word = accept & p_legal;

    // No LI expansion in this build, so the follow-up flag never matters.
    logic unused_two;
    assign unused_two = p_two;
`endif

    instr_pack u_pack (
        .kind     (p_kind),
        .code     (p_code),
        .rs       (p_rs),
        .rt       (p_rt),
        .rd       (p_rd),
        .sa       (p_sa),
        .imm      (p_imm),
        .word     (p_word),
        .legal    (p_legal),
        .two_word (p_two)
    );

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            err_q       <= 1'b0;
        end else begin
            // Address tracks completed handshakes, so a word loaded in the
            // same cycle the previous one drains picks up the advanced value.
            if (out_valid_q && bus.out_ready) begin
                out_addr_q <= out_addr_q + 32'd4;
            end
            if (load_word) begin
                out_valid_q <= 1'b1;
                out_instr_q <= p_word;
            end else if (out_free) begin
                out_valid_q <= 1'b0;
            end
            if (accept && !p_legal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign err           = err_q;

endmodule
